// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
// State, owner and request bundle definitions.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_addr_check.sv
// Request validity: word alignment and memory range.
// Purely combinational.
module dmem_addr_check #(
  parameter int WORDS = 16384
) (
  input  logic [31:0] i_addr,
  output logic        o_err
);
  import dmem_pkg::*;

  localparam logic [31:0] ALIGN_MASK = 32'(WORD_BYTES - 1);
  localparam logic [31:0] DEPTH      = 32'(WORDS);

  logic w_misaligned;
  logic w_oob;

  assign w_misaligned = (i_addr & ALIGN_MASK) != '0;
  assign w_oob        = {2'b00, i_addr[31:2]} >= DEPTH;
  assign o_err        = w_misaligned | w_oob;

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for a single-port data memory.
// CPU has priority; DMA wins after STARVE_LIMIT waits.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int WORDS        = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] mem_rdata
);
  import dmem_pkg::*;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_next;
  owner_t      r_owner;
  owner_t      w_gnt_owner;
  req_t        r_req;
  req_t        w_sel;
  logic        r_err;
  logic        w_sel_err;
  logic        w_grant;
  logic        w_dma_wins;
  logic        w_cpu_wins;
  logic [3:0]  r_starve;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_dma_rdata;
  logic [31:0] w_rd_load;
  logic        w_access;
  logic        w_done;

  // DMA takes the slot alone, or once the CPU has used up its quota
  assign w_dma_wins = dma_req && (!cpu_req || r_starve == LIMIT);
  assign w_cpu_wins = cpu_req && !w_dma_wins;

  always_comb begin
    w_grant     = 1'b0;
    w_gnt_owner = OWN_CPU;
    if (r_state == IDLE) begin
      unique case (1'b1)
        w_dma_wins: begin
          w_grant     = 1'b1;
          w_gnt_owner = OWN_DMA;
        end
        w_cpu_wins: begin
          w_grant     = 1'b1;
          w_gnt_owner = OWN_CPU;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_sel.we    = cpu_we;
    w_sel.addr  = cpu_addr;
    w_sel.wdata = cpu_wdata;
    if (w_gnt_owner == OWN_DMA) begin
      w_sel.we    = dma_we;
      w_sel.addr  = dma_addr;
      w_sel.wdata = dma_wdata;
    end
  end

  dmem_addr_check #(
    .WORDS (WORDS)
  ) u_chk (
    .i_addr (w_sel.addr),
    .o_err  (w_sel_err)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_next = ACCESS;
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_rd_load = r_err ? 32'd0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_CPU;
      r_req       <= '0;
      r_err       <= 1'b0;
      r_starve    <= 4'd0;
      r_cpu_rdata <= 32'd0;
      r_dma_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner <= w_gnt_owner;
        r_req   <= w_sel;
        r_err   <= w_sel_err;
        if (w_gnt_owner == OWN_DMA) begin
          r_starve <= 4'd0;
        end else if (dma_req) begin
          r_starve <= r_starve + 4'd1;
        end
      end
      if (r_state == ACCESS && !r_req.we) begin
        if (r_owner == OWN_DMA) r_dma_rdata <= w_rd_load;
        else                    r_cpu_rdata <= w_rd_load;
      end
    end
  end

  assign w_access  = r_state == ACCESS;
  assign w_done    = r_state == DONE;

  assign MemWrite  = w_access && r_req.we && !r_err;
  assign MemRead   = w_access && !r_req.we && !r_err;
  assign mem_addr  = w_access ? r_req.addr : 32'd0;
  assign mem_wdata = w_access ? r_req.wdata : 32'd0;

  assign cpu_ack   = w_done && r_owner == OWN_CPU;
  assign dma_ack   = w_done && r_owner == OWN_DMA;
  assign cpu_err   = cpu_ack && r_err;
  assign dma_err   = dma_ack && r_err;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random
// CPU/DMA traffic scored against a transaction-level model.
module tb_dmem_arbiter;

  localparam int WORDS = 16384;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack, dma_err;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        MemWrite, MemRead;

  dmem_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .WORDS        (WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_err   (dma_err),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: writes on rising edge, combinational read
  logic [31:0] mem [WORDS];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'd0;
      mem_ready <= 1'b1;
    end else if (MemWrite) begin
      mem[mem_addr[15:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[15:2]];

  int wr_cnt = 0;
  int rd_cnt = 0;
  always @(negedge clk) begin
    if (MemWrite) wr_cnt++;
    if (MemRead) rd_cnt++;
  end

  int errors = 0;
  int checks = 0;

  // Transaction-level reference model
  logic [31:0] ref_mem [WORDS];
  int          m_starve = 0;
  logic [31:0] exp_cpu_rd = 32'd0;
  logic [31:0] exp_dma_rd = 32'd0;

  function automatic logic addr_ok(input logic [31:0] a);
    return a[1:0] == 2'b00 && a[31:2] < 30'(WORDS);
  endfunction

  function automatic void model_txn(
    input  logic        is_dma,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic        rival_waiting,
    output logic        e_err,
    output logic [31:0] e_rd
  );
    e_err = !addr_ok(a);
    if (we) begin
      if (!e_err) ref_mem[a[15:2]] = wd;
      e_rd = is_dma ? exp_dma_rd : exp_cpu_rd;
    end else begin
      e_rd = e_err ? 32'd0 : ref_mem[a[15:2]];
      if (is_dma) exp_dma_rd = e_rd;
      else        exp_cpu_rd = e_rd;
    end
    if (is_dma)             m_starve = 0;
    else if (rival_waiting) m_starve = m_starve + 1;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0)
      return 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(1, 3));
    else if (k == 1)
      return 32'(WORDS * 4) + 32'($urandom_range(0, 255) << 2);
    else if (k < 5)
      return 32'((WORDS - 1 - $urandom_range(0, 3)) << 2);
    else
      return 32'($urandom_range(0, 15) << 2);
  endfunction

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic run_pair(
    input logic cv, input logic cwe,
    input logic [31:0] ca, input logic [31:0] cd,
    input logic dv, input logic dwe,
    input logic [31:0] da, input logic [31:0] dd
  );
    int          cyc, w0, r0, exp_w, exp_r;
    logic        cpend, dpend, first_dma, seen;
    logic        e_err;
    logic [31:0] e_rd;
    @(posedge clk); #1;
    first_dma = dv && (!cv || m_starve == LIMIT);
    exp_w = int'(cv && cwe && addr_ok(ca)) + int'(dv && dwe && addr_ok(da));
    exp_r = int'(cv && !cwe && addr_ok(ca)) + int'(dv && !dwe && addr_ok(da));
    w0 = wr_cnt; r0 = rd_cnt;
    cpu_req = cv; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dv; dma_we = dwe; dma_addr = da; dma_wdata = dd;
    cpend = cv; dpend = dv; seen = 0; cyc = 0;
    while ((cpend || dpend) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if ((cpu_ack && !cpend) || (dma_ack && !dpend) || (cpu_ack && dma_ack)) begin
        checks++; errors++;
        $display("FAIL stray_ack cpu_ack=%0b dma_ack=%0b cyc=%0d", cpu_ack, dma_ack, cyc);
      end
      if ((cpu_ack && cpend) || (dma_ack && dpend)) begin
        checks++;
        if (!seen && (dma_ack !== first_dma || cyc != 2)) begin
          errors++;
          $display("FAIL first_grant dma=%0b cyc=%0d expected dma=%0b cyc=2", dma_ack, cyc, first_dma);
        end else if (seen && cyc != 5) begin
          errors++;
          $display("FAIL second_grant_latency cyc=%0d expected 5", cyc);
        end
        seen = 1;
      end
      if (cpu_ack && cpend) begin
        model_txn(1'b0, cwe, ca, cd, dpend, e_err, e_rd);
        checks++;
        if (cpu_err !== e_err) begin
          errors++;
          $display("FAIL cpu_err addr=%h got %b expected %b", ca, cpu_err, e_err);
        end
        checks++;
        if (cpu_rdata !== e_rd) begin
          errors++;
          $display("FAIL cpu_rdata addr=%h got %h expected %h", ca, cpu_rdata, e_rd);
        end
        checks++;
        if (dma_rdata !== exp_dma_rd) begin
          errors++;
          $display("FAIL dma_rdata_hold got %h expected %h", dma_rdata, exp_dma_rd);
        end
        cpend = 0; cpu_req = 0;
      end
      if (dma_ack && dpend) begin
        model_txn(1'b1, dwe, da, dd, cpend, e_err, e_rd);
        checks++;
        if (dma_err !== e_err) begin
          errors++;
          $display("FAIL dma_err addr=%h got %b expected %b", da, dma_err, e_err);
        end
        checks++;
        if (dma_rdata !== e_rd) begin
          errors++;
          $display("FAIL dma_rdata addr=%h got %h expected %h", da, dma_rdata, e_rd);
        end
        checks++;
        if (cpu_rdata !== exp_cpu_rd) begin
          errors++;
          $display("FAIL cpu_rdata_hold got %h expected %h", cpu_rdata, exp_cpu_rd);
        end
        dpend = 0; dma_req = 0;
      end
    end
    checks++;
    if (cpend || dpend) begin
      errors++;
      $display("FAIL ack_timeout cpu_pending=%0b dma_pending=%0b", cpend, dpend);
      idle_inputs();
    end
    checks++;
    if (wr_cnt - w0 != exp_w || rd_cnt - r0 != exp_r) begin
      errors++;
      $display("FAIL strobes wr=%0d rd=%0d expected wr=%0d rd=%0d",
               wr_cnt - w0, rd_cnt - r0, exp_w, exp_r);
    end
    @(posedge clk); #1;
    checks++;
    if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_width cpu_ack=%0b dma_ack=%0b expected 0", cpu_ack, dma_ack);
    end
  endtask

  task automatic test_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h55;
    dma_req = 1; dma_we = 0; dma_addr = 32'h20; dma_wdata = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_ack, cpu_err, cpu_rdata, dma_ack, dma_err, dma_rdata,
         mem_addr, mem_wdata, MemWrite, MemRead} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero, mem_addr=%h MemWrite=%b expected all 0",
               mem_addr, MemWrite);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    m_starve = 0; exp_cpu_rd = 0; exp_dma_rd = 0;
  endtask

  task automatic test_cpu_write_read();
    run_pair(1, 1, 32'h4, 32'hABC, 0, 0, 0, 0);
    run_pair(1, 0, 32'h4, 32'h0, 0, 0, 0, 0);
    checks++;
    if (cpu_rdata !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL cpu_readback got %h expected 00000abc", cpu_rdata);
    end
  endtask

  task automatic test_dma_then_cpu();
    run_pair(0, 0, 0, 0, 1, 1, 32'hC008, 32'hCBA);
    run_pair(1, 0, 32'hC008, 0, 0, 0, 0, 0);
    checks++;
    if (cpu_rdata !== 32'h0000_0CBA || mem[14'h3002] !== 32'h0000_0CBA) begin
      errors++;
      $display("FAIL dma_to_cpu got %h mem=%h expected 00000cba", cpu_rdata, mem[14'h3002]);
    end
  endtask

  task automatic test_starvation();
    int   acks, cyc;
    logic exp_dma, e_err;
    logic [31:0] e_rd;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h4;
    acks = 0; cyc = 0;
    while (acks < 10 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ack || dma_ack) begin
        exp_dma = m_starve == LIMIT;
        checks++;
        if (dma_ack !== exp_dma || cpu_ack !== !exp_dma) begin
          errors++;
          $display("FAIL starve_grant n=%0d dma_ack=%0b cpu_ack=%0b expected dma=%0b",
                   acks, dma_ack, cpu_ack, exp_dma);
        end
        model_txn(dma_ack, 1'b0, dma_ack ? 32'h4 : 32'h0, 0, 1'b1, e_err, e_rd);
        acks++;
      end
    end
    checks++;
    if (acks < 10) begin
      errors++;
      $display("FAIL starve_timeout acks=%0d expected 10", acks);
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    run_pair(1, 0, 32'h6, 0, 0, 0, 0, 0);
    run_pair(0, 0, 0, 0, 1, 1, 32'h0001_0000, 32'hFACE);
    checks++;
    for (int i = 0; i < WORDS; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL mem_unchanged word=%0d got %h expected %h", i, mem[i], ref_mem[i]);
        break;
      end
    end
  endtask

  task automatic test_reset_in_access();
    int cyc;
    run_pair(1, 1, 32'h8, 32'h1111_1111, 0, 0, 0, 0);
    @(posedge clk); #1;
    dma_req = 1; dma_we = 1; dma_addr = 32'h8; dma_wdata = 32'hDEAD_BEEF;
    cyc = 0;
    while (!MemWrite && cyc < 6) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!MemWrite) begin
      errors++;
      $display("FAIL dma_access_timeout MemWrite=%b expected 1", MemWrite);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({MemWrite, MemRead, mem_addr, mem_wdata, cpu_ack, dma_ack,
         cpu_rdata, dma_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid_access MemWrite=%b mem_addr=%h expected 0",
               MemWrite, mem_addr);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    m_starve = 0; exp_cpu_rd = 0; exp_dma_rd = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dma_ack !== 1'b0 || cpu_ack !== 1'b0) begin
        errors++;
        $display("FAIL ack_after_reset cyc=%0d dma_ack=%b expected 0", i, dma_ack);
      end
    end
    run_pair(1, 0, 32'h8, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int mode;
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      run_pair(mode != 1, 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
               mode != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
    end
    checks++;
    for (int i = 0; i < WORDS; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL random_mem word=%0d got %h expected %h", i, mem[i], ref_mem[i]);
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;
    idle_inputs();
    test_reset();
    test_cpu_write_read();
    test_dma_then_cpu();
    test_starvation();
    test_errors();
    test_reset_in_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
